// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand/result handshake bundle for alu_pipe
`timescale 1ns/1ps
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             CarryOut;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             illegal;

    modport slave (
        input  in_valid, A, B, sel, out_ready,
        output in_ready, out_valid, out, CarryOut, zero, neg, ovf, illegal
    );

    modport master (
        output in_valid, A, B, sel, out_ready,
        input  in_ready, out_valid, out, CarryOut, zero, neg, ovf, illegal
    );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked registered ALU with flags, shifts/rotates, ADC chaining
// Optional iterative shift-add multiply on opcode C when ALU_MUL_EN is defined.
`timescale 1ns/1ps
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd1
`ifdef ALU_MUL_EN
        , BUSY = 2'd2
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q;
    logic             cout_q, zero_q, neg_q, ovf_q, ill_q, carry_q;
    logic             accept, load_alu;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   ext;
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0] res;
    logic             res_c, res_v, res_ill;

    assign bus.in_ready  = ~rst & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = out_q;
    assign bus.CarryOut  = cout_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;
    assign bus.illegal   = ill_q;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mcand_q, prod_q, prod_next;
    logic [WIDTH-1:0]   mplier_q;
    logic [SHW-1:0]     cnt_q;
    logic               is_mul;

    assign is_mul    = (bus.sel == 4'hC);
    assign load_alu  = accept & ~is_mul;
    assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
`else
    assign load_alu  = accept;
`endif

    // Single-cycle result; ext carries the shifted-out/borrow bit alongside the result
    always_comb begin
        shamt   = bus.B[SHW-1:0];
        ext     = '0;
        dbl     = '0;
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_ill = 1'b0;
        case (bus.sel)
            4'h0, 4'h8: begin
                ext   = {1'b0, bus.A} + {1'b0, bus.B}
                      + {{WIDTH{1'b0}}, (bus.sel == 4'h8) & carry_q};
                res   = ext[WIDTH-1:0];
                res_c = ext[WIDTH];
                res_v = (bus.A[MSB] == bus.B[MSB]) & (res[MSB] != bus.A[MSB]);
            end
            4'h1: begin
                ext   = {1'b0, bus.A} - {1'b0, bus.B};
                res   = ext[WIDTH-1:0];
                res_c = ext[WIDTH];
                res_v = (bus.A[MSB] != bus.B[MSB]) & (res[MSB] != bus.A[MSB]);
            end
            4'h2: res = bus.A & bus.B;
            4'h3: res = bus.A | bus.B;
            4'h4: res = bus.A ^ bus.B;
            4'h5: begin
                ext   = {1'b0, bus.A} << shamt;
                res   = ext[WIDTH-1:0];
                res_c = ext[WIDTH];
            end
            4'h6: begin
                ext   = {bus.A, 1'b0} >> shamt;
                res   = ext[WIDTH:1];
                res_c = ext[0];
            end
            4'h7: res = bus.A;
            4'h9: begin
                ext   = $signed({bus.A, 1'b0}) >>> shamt;
                res   = ext[WIDTH:1];
                res_c = ext[0];
            end
            4'hA: begin
                dbl = {bus.A, bus.A} << shamt;
                res = dbl[2*WIDTH-1:WIDTH];
            end
            4'hB: begin
                dbl = {bus.A, bus.A} >> shamt;
                res = dbl[WIDTH-1:0];
            end
            default: res_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
`ifdef ALU_MUL_EN
                    state_d = is_mul ? BUSY : DONE;
`else
                    state_d = DONE;
`endif
                end else if (state_q == DONE && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
`ifdef ALU_MUL_EN
            BUSY: if (cnt_q == SHW'(WIDTH - 1)) state_d = DONE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_alu) begin
                out_q  <= res;
                cout_q <= res_c;
                ovf_q  <= res_v;
                ill_q  <= res_ill;
                zero_q <= (res == '0);
                neg_q  <= res[MSB];
                if (bus.sel == 4'h0 || bus.sel == 4'h1 || bus.sel == 4'h8)
                    carry_q <= res_c;
            end
`ifdef ALU_MUL_EN
            if (accept && is_mul) begin
                mcand_q  <= {{WIDTH{1'b0}}, bus.A};
                mplier_q <= bus.B;
                prod_q   <= '0;
                cnt_q    <= '0;
            end else if (state_q == BUSY) begin
                prod_q   <= prod_next;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    out_q  <= prod_next[WIDTH-1:0];
                    cout_q <= |prod_next[2*WIDTH-1:WIDTH];
                    ovf_q  <= 1'b0;
                    ill_q  <= 1'b0;
                    zero_q <= (prod_next[WIDTH-1:0] == '0);
                    neg_q  <= prod_next[MSB];
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe (WIDTH=8), with or without ALU_MUL_EN
`timescale 1ns/1ps
module tb_alu_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(8)) bus();
    alu_pipe #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [7:0] o;
        logic       c, z, n, v, il;
    } exp_t;

    exp_t sb[$];
    int   total = 0, bad = 0, pushed = 0, popped = 0;
    logic mcarry = 1'b0;

`ifdef ALU_MUL_EN
    localparam int MUL_LAT = 9;
`else
    localparam int MUL_LAT = 1;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [3:0] s, input logic cin);
        exp_t e;
        int ua, ub, sa, sbv, r, sh;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sbv = int'($signed(b));
        sh = int'(b[2:0]);
        e = '0;
        case (s)
            4'h0: begin r = ua + ub; e.o = 8'(r); e.c = r[8];
                        e.v = (sa + sbv > 127) || (sa + sbv < -128); end
            4'h1: begin r = ua - ub; e.o = 8'(r); e.c = (ua < ub);
                        e.v = (sa - sbv > 127) || (sa - sbv < -128); end
            4'h8: begin r = ua + ub + int'(cin); e.o = 8'(r); e.c = r[8];
                        e.v = (sa + sbv + int'(cin) > 127) || (sa + sbv + int'(cin) < -128); end
            4'h2: e.o = a & b;
            4'h3: e.o = a | b;
            4'h4: e.o = a ^ b;
            4'h5: begin e.o = a << sh; e.c = (sh != 0) ? a[8-sh] : 1'b0; end
            4'h6: begin e.o = a >> sh; e.c = (sh != 0) ? a[sh-1] : 1'b0; end
            4'h7: e.o = a;
            4'h9: begin e.o = 8'($signed(a) >>> sh); e.c = (sh != 0) ? a[sh-1] : 1'b0; end
            4'hA: begin e.o = a; for (int i = 0; i < sh; i++) e.o = {e.o[6:0], e.o[7]}; end
            4'hB: begin e.o = a; for (int i = 0; i < sh; i++) e.o = {e.o[0], e.o[7:1]}; end
`ifdef ALU_MUL_EN
            4'hC: begin r = ua * ub; e.o = 8'(r); e.c = ((r >> 8) != 0); end
`endif
            default: e.il = 1'b1;
        endcase
        e.z = (e.o == 8'h00);
        e.n = e.o[7];
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check_eq("extra_beat", 32'(sb.size()), 32'(1));
            end else begin
                e = sb.pop_front();
                popped++;
                check_eq("out",     32'(bus.out),      32'(e.o));
                check_eq("carry",   32'(bus.CarryOut), 32'(e.c));
                check_eq("zero",    32'(bus.zero),     32'(e.z));
                check_eq("neg",     32'(bus.neg),      32'(e.n));
                check_eq("ovf",     32'(bus.ovf),      32'(e.v));
                check_eq("illegal", 32'(bus.illegal),  32'(e.il));
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        int   n;
        exp_t e;
        n = 0;
        bus.A = a; bus.B = b; bus.sel = s; bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 50) begin
                check_eq("send_timeout", 32'(n), 32'(0));
                bus.in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        e = model(a, b, s, mcarry);
        if (s == 4'h0 || s == 4'h1 || s == 4'h8) mcarry = e.c;
        sb.push_back(e);
        pushed++;
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        check_eq("drain", 32'(sb.size()), 32'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_vld"},  32'(bus.out_valid), 32'(0));
        check_eq({tag, "_out"},  32'(bus.out),       32'(0));
        check_eq({tag, "_c"},    32'(bus.CarryOut),  32'(0));
        check_eq({tag, "_z"},    32'(bus.zero),      32'(0));
        check_eq({tag, "_n"},    32'(bus.neg),       32'(0));
        check_eq({tag, "_v"},    32'(bus.ovf),       32'(0));
        check_eq({tag, "_il"},   32'(bus.illegal),   32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.sel = '0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        check_eq("rst_rdy", 32'(bus.in_ready), 32'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("idle_rdy", 32'(bus.in_ready), 32'(1));
        @(posedge clk); #1;

        send(8'hF0, 8'h20, 4'h0);
        @(negedge clk);
        check_eq("lat1", 32'(bus.out_valid), 32'(1));
        check_eq("add_out", 32'(bus.out), 32'(8'h10));
        @(posedge clk); #1;

        send(8'h7F, 8'h01, 4'h0);
        send(8'h03, 8'h05, 4'h1);
        send(8'h00, 8'h00, 4'h8);
        send(8'h81, 8'h01, 4'h5);
        send(8'h80, 8'h03, 4'h9);
        send(8'h01, 8'h01, 4'hB);
        send(8'h5A, 8'h00, 4'h6);
        send(8'h5A, 8'h00, 4'h5);
        send(8'h96, 8'h07, 4'h6);
        send(8'h81, 8'h03, 4'hA);
        send(8'h80, 8'h80, 4'h1);
        send(8'hFF, 8'h00, 4'h8);
        send(8'h12, 8'h34, 4'hE);
        drain();

        fork
            for (int i = 0; i < 30; i++)
                send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
            for (int i = 0; i < 80; i++) begin
                @(posedge clk); #1 bus.out_ready = 1'($urandom_range(0, 1));
            end
        join
        bus.out_ready = 1'b1;
        drain();

        bus.out_ready = 1'b0;
        send(8'h11, 8'h22, 4'h0);
        fork
            begin
                send(8'h33, 8'h44, 4'h0);
                send(8'h55, 8'h66, 4'h0);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    check_eq("hold_vld", 32'(bus.out_valid), 32'(1));
                    check_eq("hold_out", 32'(bus.out),       32'(8'h33));
                    check_eq("hold_rdy", 32'(bus.in_ready),  32'(0));
                end
                @(posedge clk); #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        send(8'h10, 8'h11, 4'hC);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!bus.out_valid) check_eq("busy_rdy", 32'(bus.in_ready), 32'(0));
        end while (!bus.out_valid && n < 20);
        check_eq("mul_lat", 32'(n), 32'(MUL_LAT));
        @(posedge clk); #1;
        drain();

        bus.out_ready = 1'b0;
        send(8'h01, 8'h01, 4'h0);
        @(negedge clk);
        check_eq("pre_rst_vld", 32'(bus.out_valid), 32'(1));
        @(posedge clk); #1 rst = 1'b1;
        void'(sb.pop_back()); pushed--; mcarry = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_all_zero("rst_done");
        @(posedge clk); #1 rst = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq("post_rst_rdy", 32'(bus.in_ready), 32'(1));
        @(posedge clk); #1;

`ifdef ALU_MUL_EN
        send(8'h10, 8'h11, 4'hC);
        idle(3);
        rst = 1'b1;
        void'(sb.pop_back()); pushed--; mcarry = 1'b0;
        @(negedge clk);
        check_eq("rst_mul_rdy", 32'(bus.in_ready), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check_all_zero("rst_mul");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mul_rdy2", 32'(bus.in_ready), 32'(1));
        idle(12);
        check_eq("rst_mul_novld", 32'(bus.out_valid), 32'(0));
`endif

        send(8'h00, 8'h00, 4'h8);
        send(8'hAB, 8'hCD, 4'hE);
        send(8'h10, 8'h11, 4'hC);
        drain();
        check_eq("beats", 32'(popped), 32'(pushed));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
